// File: rtl/down_mod12_pkg.sv
// Shared definitions for the MOD12 down-counting reload timer.
// Holds the count modulus, counter width, FSM state encoding and the
// load-value clamp used by down_mod12_timer.
package down_mod12_pkg;

  localparam int MOD    = 12;
  localparam int WIDTH  = 4;
  localparam int MAXVAL = MOD - 1;

  typedef logic [WIDTH-1:0] cnt_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Largest legal count as a counter-width value.
  localparam cnt_t MAX_CNT = cnt_t'(MAXVAL);

  // True when a requested load value lies outside 0..MOD-1.
  function automatic logic load_out_of_range(input cnt_t value);
    return (value > MAX_CNT);
  endfunction

  // Saturate a requested load value into the legal count range.
  function automatic cnt_t clamp_load(input cnt_t value);
    return load_out_of_range(value) ? MAX_CNT : value;
  endfunction

endpackage

// File: rtl/down_mod12_timer.sv
// Loadable MOD12 down counter with IDLE/RUN/DONE control FSM.
// Counts toward zero while enabled in RUN; at each zero crossing it either
// reloads MOD-1 (periodic, mode=0) or parks at zero in DONE (one-shot,
// mode=1), and raises tc for exactly one cycle.
// Optional build macro DOWN_MOD12_TIMER_LOAD_ERR_EN adds a registered
// load_err pulse flagging loads whose din exceeded MOD-1.
module down_mod12_timer
  import down_mod12_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  input  logic             en,
  input  logic             mode,
  output logic [WIDTH-1:0] dout,
  output logic             tc,
  output logic             busy,
  output logic             done
`ifdef DOWN_MOD12_TIMER_LOAD_ERR_EN
  ,
  output logic             load_err
`endif
);

  state_t state;
  cnt_t   count;
  logic   tc_q;
  cnt_t   load_val;
  logic   load_oor;
  logic   at_zero;

  // Clamp the requested load into 0..MOD-1 and note whether clamping was needed
  always_comb begin
    load_oor = load_out_of_range(din);
    load_val = clamp_load(din);
    at_zero  = (count == '0);
  end

  // Counter and FSM share one register block; priority is rst, then load, then counting
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      tc_q  <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      if (load) begin
        count <= load_val;
        state <= RUN;
      end else begin
        unique case (state)
          IDLE: begin
            count <= count;
          end
          RUN: begin
            if (en) begin
              if (at_zero) begin
                tc_q <= 1'b1;
                if (mode) begin
                  state <= DONE;
                end else begin
                  count <= MAX_CNT;
                end
              end else begin
                count <= count - cnt_t'(1);
              end
            end
          end
          DONE: begin
            count <= '0;
          end
          default: begin
            state <= IDLE;
            count <= '0;
          end
        endcase
      end
    end
  end

`ifdef DOWN_MOD12_TIMER_LOAD_ERR_EN
  // Flag for one cycle any accepted load whose value had to be clamped
  always_ff @(posedge clk) begin
    if (rst) begin
      load_err <= 1'b0;
    end else begin
      load_err <= load & load_oor;
    end
  end
`endif

  assign dout = count;
  assign tc   = tc_q;
  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule
